// File: rtl/bp_fe_queue_sender.sv
// bp_fe_queue_sender: formats FE fetch responses and fetch exceptions into
// FE queue messages, buffers them in a small FIFO and hands them to the BE
// over valid/ready. After an exception message is queued, fetch is held off
// until the BE redirects with a flush.
module bp_fe_queue_sender #(
  parameter  int vaddr_width_p               = 39,
  parameter  int instr_width_p               = 32,
  parameter  int branch_metadata_fwd_width_p = 36,
  parameter  int els_p                       = 2,
  localparam int fe_queue_width_lp           = 3 + vaddr_width_p + instr_width_p
                                               + branch_metadata_fwd_width_p
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   flush_i,
  input  logic                                   fetch_v_i,
  output logic                                   fetch_ready_o,
  input  logic [vaddr_width_p-1:0]               fetch_pc_i,
  input  logic [instr_width_p-1:0]               fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_metadata_i,
  input  logic                                   itlb_miss_i,
  input  logic                                   instr_page_fault_i,
  input  logic                                   instr_access_fault_i,
  output logic [fe_queue_width_lp-1:0]           fe_queue_o,
  output logic                                   fe_queue_v_o,
  input  logic                                   fe_queue_ready_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [cnt_w_lp-1:0] els_cnt_lp = cnt_w_lp'(els_p);

  typedef enum logic {
    e_run,
    e_stall
  } state_e;

  state_e                         state_q;
  logic                           reset_done_q;
  logic [fe_queue_width_lp-1:0]   mem_q [els_p];
  logic [ptr_w_lp-1:0]            wptr_q, wptr_d;
  logic [ptr_w_lp-1:0]            rptr_q, rptr_d;
  logic [cnt_w_lp-1:0]            count_q, count_d;

  logic                           exc_v;
  logic [1:0]                     exc_code;
  logic [instr_width_p-1:0]       instr_field;
  logic [fe_queue_width_lp-1:0]   msg_d;
  logic                           enq;
  logic                           deq;

  // Build the outgoing message; exceptions carry no instruction and report
  // the highest-priority fault (access > page > itlb miss).
  always_comb begin
    exc_v = itlb_miss_i | instr_page_fault_i | instr_access_fault_i;
    exc_code = 2'd0;
    if (instr_access_fault_i) begin
      exc_code = 2'd2;
    end else if (instr_page_fault_i) begin
      exc_code = 2'd1;
    end
    instr_field = exc_v ? '0 : fetch_instr_i;
    msg_d = {exc_v, exc_code, fetch_pc_i, instr_field, fetch_metadata_i};
  end

  // Ready and valid come straight from registers so no input reaches an output.
  assign fetch_ready_o = reset_done_q & (count_q < els_cnt_lp) & (state_q == e_run);
  assign fe_queue_v_o  = (count_q != '0);
  assign fe_queue_o    = mem_q[rptr_q];

  assign enq = fetch_v_i & fetch_ready_o & ~flush_i;
  assign deq = fe_queue_v_o & fe_queue_ready_i;

  // Pointer and occupancy update; a flush wipes the FIFO regardless of traffic.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (deq) begin
        rptr_d = rptr_q + 1'b1;
      end
      if (enq & ~deq) begin
        count_d = count_q + 1'b1;
      end else if (~enq & deq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control registers and the run/stall state machine.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_run;
      reset_done_q <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      reset_done_q <= 1'b1;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      case (state_q)
        e_run: begin
          if (enq & exc_v) begin
            state_q <= e_stall;
          end
        end
        e_stall: begin
          if (flush_i) begin
            state_q <= e_run;
          end
        end
        default: state_q <= e_run;
      endcase
    end
  end

  // Message storage; contents need no reset because valid is gated by count.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q] <= msg_d;
    end
  end

endmodule
